// File: rtl/sdram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb
// Purpose  : Two-requester Avalon-MM arbiter in front of a single SDRAM
//            controller slave. One command is forwarded at a time. Read
//            responses are steered back to the requester that issued the
//            read, using an in-order FIFO of requester ids.
// Revision : 1.0 - initial release
//
// Parameters
//   MAX_OUTSTANDING  depth of the outstanding-read id FIFO (power of two, 2..16)
//
// Optional build macro
//   SDRAM_ARB_RR_EN  defined   : round-robin on simultaneous requests
//                    undefined : fixed priority, m0 wins contention
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   m0_* / m1_*                 requester Avalon-MM slave-side ports
//                               (address, read, write, writedata in;
//                                waitrequest, readdata, readdatavalid out)
//   s_address/s_read/s_write/
//   s_writedata                 command to the SDRAM controller
//   s_waitrequest/s_readdata/
//   s_readdatavalid             response from the SDRAM controller
// ============================================================================
module sdram_arb #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // requester 0
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   // requester 1
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   // SDRAM controller
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid
);

   localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e                     state_q,    state_d;
   logic                       grant_id_q, grant_id_d;
   logic [MAX_OUTSTANDING-1:0] fifo_q,     fifo_d;
   logic [AW-1:0]              wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]              rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]              count_q,    count_d;
`ifdef SDRAM_ARB_RR_EN
   logic                       last_grant_q, last_grant_d;
`endif

   logic        fifo_full;
   logic        fifo_empty;
   logic        req0;
   logic        req1;
   logic        arb_id;
   logic [31:0] g_addr;
   logic [31:0] g_wdata;
   logic        g_rd;
   logic        g_wr;
   logic        accept;
   logic        push;
   logic        pop;
   logic        head_id;

   assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);

   // A read+write request counts as a write, so it stays grantable when the
   // FIFO is full; a pure read is held off until a slot frees up.
   assign req0 = m0_write | (m0_read & ~fifo_full);
   assign req1 = m1_write | (m1_read & ~fifo_full);

   always_comb begin
`ifdef SDRAM_ARB_RR_EN
      if (req0 && req1) begin
         arb_id = ~last_grant_q;
      end else begin
         arb_id = ~req0;
      end
`else
      arb_id = ~req0;
`endif
   end

   // Granted requester's command, with write taking precedence over read.
   // The full gate on reads only matters if a requester granted for a write
   // switches to a read mid-grant; it keeps the id FIFO from overflowing.
   assign g_addr  = grant_id_q ? m1_address   : m0_address;
   assign g_wdata = grant_id_q ? m1_writedata : m0_writedata;
   assign g_wr    = grant_id_q ? m1_write     : m0_write;
   assign g_rd    = (grant_id_q ? m1_read : m0_read) & ~g_wr & ~fifo_full;

   // Command and stall outputs. Outputs are forced to their idle values while
   // rst_n is low so nothing leaks out during reset.
   always_comb begin
      s_address      = g_addr;
      s_writedata    = g_wdata;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      if (rst_n && (state_q == GRANT)) begin
         s_read  = g_rd;
         s_write = g_wr;
         // A dropped request must not see waitrequest low, otherwise the
         // requester would believe a command was taken.
         if (g_rd || g_wr) begin
            if (grant_id_q) begin
               m1_waitrequest = s_waitrequest;
            end else begin
               m0_waitrequest = s_waitrequest;
            end
         end
      end
   end

   assign accept  = (s_read | s_write) & ~s_waitrequest;
   assign push    = accept & s_read;
   // Responses with nothing outstanding are discarded.
   assign pop     = s_readdatavalid & ~fifo_empty & rst_n;
   assign head_id = fifo_q[rd_ptr_q];

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = pop & ~head_id;
   assign m1_readdatavalid = pop &  head_id;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
`ifdef SDRAM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d    = GRANT;
               grant_id_d = arb_id;
`ifdef SDRAM_ARB_RR_EN
               last_grant_d = arb_id;
`endif
            end
         end
         GRANT: begin
            // Leave after one accepted transfer, or when the requester
            // withdraws without one.
            if (!(g_rd || g_wr) || accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outstanding-read id FIFO
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = grant_id_q;
         wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_id_q <= 1'b0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
`ifdef SDRAM_ARB_RR_EN
         // Makes m0 the winner of the first contention after reset.
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
`ifdef SDRAM_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, depth of the outstanding-read tracking FIFO (power of two, 2..16).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 m0_address / m1_address  input  32 each  requester byte address.
REQ-005 m0_read, m0_write / m1_read, m1_write  input  1 each  Avalon-MM read/write requests.
REQ-006 m0_writedata / m1_writedata  input  32 each  write data.
REQ-007 m0_waitrequest / m1_waitrequest  output  1 each  stall to requester.
REQ-008 m0_readdata / m1_readdata  output  32 each  read data.
REQ-009 m0_readdatavalid / m1_readdatavalid  output  1 each  read data strobe.
REQ-010 s_address  output  32; s_read, s_write  output  1; s_writedata  output  32; these form the command side to the SDRAM controller slave.
REQ-011 s_waitrequest  input  1; s_readdata  input  32; s_readdatavalid  input  1; these form the response side from the SDRAM controller.

Function
REQ-012 The FSM SHALL have two states: IDLE (no command driven; s_read=s_write=0, both m*_waitrequest=1) and GRANT (granted requester passed through to slave).
REQ-013 In IDLE, the block SHALL latch grant_id on a rising edge when any requester asserts read or write; GRANT begins the next cycle (1-cycle arbitration latency).
REQ-014 In GRANT, s_address, s_read, s_write and s_writedata SHALL equal the granted requester's signals combinationally; granted m*_waitrequest SHALL equal s_waitrequest; non-granted waitrequest SHALL be 1.
REQ-015 Acceptance SHALL occur when (s_read|s_write)&!s_waitrequest; the FSM SHALL return to IDLE on the next edge (max one transfer per 2 cycles).
REQ-016 The grant SHALL be held unchanged while s_waitrequest=1; there is no preemption.
REQ-017 If the granted requester deasserts both read and write in GRANT, the FSM SHALL return to IDLE without a transfer.
REQ-018 A requester asserting read and write together SHALL be treated as a write; read is ignored.
REQ-019 Each accepted read SHALL push grant_id into the outstanding FIFO; each s_readdatavalid SHALL pop the head.
REQ-020 On s_readdatavalid, s_readdata SHALL be routed to m[head]_readdata with m[head]_readdatavalid=1 in the same cycle; the other requester's readdatavalid SHALL be 0.
REQ-021 m*_readdata SHALL carry s_readdata unconditionally; only readdatavalid is gated.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-023 When the FIFO holds MAX_OUTSTANDING entries, read requesters SHALL NOT be granted; write requesters remain grantable.
REQ-024 An s_readdatavalid arriving with an empty FIFO SHALL be dropped (no m*_readdatavalid), and FIFO state SHALL remain unchanged.
REQ-025 Read responses SHALL return in acceptance order; no reordering.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL enter IDLE, empty the FIFO, and set last_grant=1 so that m0 wins the first contention.
REQ-027 During and after reset until the next grant: s_read=0, s_write=0, m0/m1_waitrequest=1, m0/m1_readdatavalid=0.
REQ-028 A reset mid-transfer SHALL abandon the transfer, and the block SHALL route no responses for reads issued before reset.

Configuration
REQ-029 Macro SDRAM_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the requester not equal to last_grant (round-robin); last_grant updates on each grant.
REQ-030 SDRAM_ARB_RR_EN undefined: fixed priority, m0 always wins contention, and last_grant is unused.

Verification
REQ-031 m0 write 0x100 data 0xDEADBEEF, s_waitrequest=0 -> s_write=1 with s_address=0x100 exactly 1 cycle after request; m0_waitrequest low that cycle.
REQ-032 m0 and m1 read continuously with RR_EN -> grants alternate m0,m1,m0,m1; without RR_EN -> m0 only while it requests.
REQ-033 m1 read 0x40, slave returns 0x12345678 3 cycles later -> m1_readdatavalid=1 with m1_readdata=0x12345678, m0_readdatavalid=0.
REQ-034 Reads issued in the order m0,m1,m0,m1 (4 outstanding, no responses) -> fifth read stalled; one response -> the stalled read is granted; responses are routed m0,m1,m0,m1.
REQ-035 s_waitrequest=1 for 5 cycles during an m0 write while m1 requests -> grant stays on m0 and s_address stable; m1 granted after acceptance.
REQ-036 rst_n=0 while in GRANT with 2 outstanding reads -> next cycle IDLE, outputs at reset values; subsequent s_readdatavalid pulses are dropped.
